// File: rtl/sram_lsu_bridge.sv
// rtl/sram_lsu_bridge.sv - LSU load/store bridge onto OpenRAM RW port 0.
// Optional macro SRAM_LSU_BRIDGE_MISALIGN_ERR_EN turns misaligned half/word accesses into errors.
module sram_lsu_bridge #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_WMASKS = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t          state, state_nxt;
  logic [31:0]     off;
  logic            err_now, accept, access;
  logic [1:0]      eff_lo;
  logic [3:0]      size_mask;
  logic            r_we, r_uns, r_err;
  logic [1:0]      r_size, r_lo;
  logic [31:0]     hold, shifted;

  // BASE_ADDR is size-aligned, so the offset's low bits equal req_addr[1:0]
  assign off    = req_addr - BASE_ADDR;
  assign accept = req_valid && req_ready;
  assign access = accept && !err_now;

  always_comb begin
    err_now = (off[31:ADDR_WIDTH+2] != '0) || (req_size == 2'd3);
`ifdef SRAM_LSU_BRIDGE_MISALIGN_ERR_EN
    if (req_size == 2'd1 && off[0])          err_now = 1'b1;
    if (req_size == 2'd2 && off[1:0] != 2'd0) err_now = 1'b1;
`endif
  end

  // Misaligned low bits are dropped so the lane position matches the natural boundary
  always_comb begin
    eff_lo    = 2'd0;
    size_mask = 4'b1111;
    din0      = req_wdata;
    case (req_size)
      2'd0: begin
        eff_lo    = off[1:0];
        size_mask = 4'b0001 << off[1:0];
        din0      = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        eff_lo    = {off[1], 1'b0};
        size_mask = 4'b0011 << {off[1], 1'b0};
        din0      = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    csb0   = !access;
    web0   = !(access && req_we);
    wmask0 = (access && req_we) ? size_mask : '0;
    addr0  = off[ADDR_WIDTH+1:2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_RESP;
      S_RESP: begin
        if (accept)         state_nxt = S_ACCESS;
        else if (rsp_ready) state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_uns  <= 1'b0;
      r_err  <= 1'b0;
      r_size <= 2'd0;
      r_lo   <= 2'd0;
      hold   <= '0;
    end else begin
      if (accept) begin
        r_we   <= req_we;
        r_uns  <= req_unsigned;
        r_err  <= err_now;
        r_size <= req_size;
        r_lo   <= eff_lo;
      end
      // dout0 is only valid around this edge, so it is captured once and held
      if (state == S_ACCESS) hold <= dout0;
    end
  end

  assign shifted = hold >> {r_lo, 3'b000};

  always_comb begin
    req_ready = rst_n && ((state == S_IDLE) || (state == S_RESP && rsp_ready));
    rsp_valid = (state == S_RESP);
    rsp_err   = (state == S_RESP) && r_err;
    rsp_rdata = '0;
    if (state == S_RESP && !r_we && !r_err) begin
      case (r_size)
        2'd0:    rsp_rdata = r_uns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
        2'd1:    rsp_rdata = r_uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        default: rsp_rdata = shifted;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_lsu_bridge.sv
// tb/tb_sram_lsu_bridge.sv - directed-vector bench for sram_lsu_bridge with a behavioural OpenRAM port model.
module tb_sram_lsu_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = 2'd0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_rdata;
  logic        csb0, web0;
  logic [3:0]  wmask0;
  logic [7:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0 = '0;

  int n_vec = 0;
  int n_err = 0;

  sram_lsu_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  always #5 clk = ~clk;

  // OpenRAM-style port: inputs registered at posedge, write/read happen at negedge
  logic [31:0] mem [256];
  logic        m_en = 1'b0, m_we = 1'b0;
  logic [7:0]  m_addr = '0;
  logic [3:0]  m_mask = '0;
  logic [31:0] m_din = '0;

  initial for (int i = 0; i < 256; i++) mem[i] = 32'd0;

  always @(posedge clk) begin
    m_en   <= !csb0;
    m_we   <= !web0;
    m_addr <= addr0;
    m_mask <= wmask0;
    m_din  <= din0;
  end

  always @(negedge clk) begin
    if (m_en && m_we) begin
      for (int b = 0; b < 4; b++)
        if (m_mask[b]) mem[m_addr][8*b +: 8] = m_din[8*b +: 8];
      dout0 <= $urandom;
    end else if (m_en) begin
      dout0 <= mem[m_addr];
    end else begin
      dout0 <= $urandom;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic exp_csb, input logic [3:0] exp_mask, input logic [7:0] exp_a0,
                        input logic [31:0] exp_din, input logic [31:0] exp_rd, input logic exp_err);
    drive(we, addr, size, uns, wdata);
    wait_ready(tag);
    check_eq({tag, " csb0"}, {31'd0, csb0}, {31'd0, exp_csb});
    check_eq({tag, " wmask0"}, {28'd0, wmask0}, {28'd0, exp_mask});
    check_eq({tag, " web0"}, {31'd0, web0}, {31'd0, exp_csb || !we});
    if (!exp_csb) begin
      check_eq({tag, " addr0"}, {24'd0, addr0}, {24'd0, exp_a0});
      check_eq({tag, " din0"}, din0, exp_din);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq({tag, " rsp_valid early"}, {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check_eq({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check_eq({tag, " rsp_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    check_eq({tag, " rsp_rdata"}, rsp_rdata, exp_rd);
    @(posedge clk); #1;
    check_eq({tag, " rsp_valid done"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    // reset with a pending store
    drive(1'b1, 32'h10, 2'd2, 1'b0, 32'h1111_2222);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst req_ready", {31'd0, req_ready}, 32'd0);
    check_eq("rst csb0", {31'd0, csb0}, 32'd1);
    check_eq("rst web0", {31'd0, web0}, 32'd1);
    check_eq("rst wmask0", {28'd0, wmask0}, 32'd0);
    check_eq("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst rsp_err", {31'd0, rsp_err}, 32'd0);
    check_eq("rst rsp_rdata", rsp_rdata, 32'd0);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk); #1;

    access("st_w", 1, 32'h10, 2'd2, 0, 32'hDEAD_BEEF, 0, 4'b1111, 8'd4, 32'hDEAD_BEEF, 32'd0, 0);
    access("st_b", 1, 32'h13, 2'd0, 0, 32'h0000_00A5, 0, 4'b1000, 8'd4, 32'hA5A5_A5A5, 32'd0, 0);
    access("ld_bs", 0, 32'h13, 2'd0, 0, 32'd0, 0, 4'b0000, 8'd4, 32'd0, 32'hFFFF_FFA5, 0);
    access("ld_bu", 0, 32'h13, 2'd0, 1, 32'd0, 0, 4'b0000, 8'd4, 32'd0, 32'h0000_00A5, 0);
    access("ld_w", 0, 32'h10, 2'd2, 0, 32'd0, 0, 4'b0000, 8'd4, 32'd0, 32'hA5AD_BEEF, 0);
    access("st_w2", 1, 32'h10, 2'd2, 0, 32'h8001_7FFF, 0, 4'b1111, 8'd4, 32'h8001_7FFF, 32'd0, 0);
    access("ld_hs_hi", 0, 32'h12, 2'd1, 0, 32'd0, 0, 4'b0000, 8'd4, 32'd0, 32'hFFFF_8001, 0);
    access("ld_hu_hi", 0, 32'h12, 2'd1, 1, 32'd0, 0, 4'b0000, 8'd4, 32'd0, 32'h0000_8001, 0);
    access("ld_hs_lo", 0, 32'h10, 2'd1, 0, 32'd0, 0, 4'b0000, 8'd4, 32'd0, 32'h0000_7FFF, 0);
    access("st_h", 1, 32'h16, 2'd1, 0, 32'h0000_1234, 0, 4'b1100, 8'd5, 32'h1234_1234, 32'd0, 0);
    access("ld_w5", 0, 32'h14, 2'd2, 0, 32'd0, 0, 4'b0000, 8'd5, 32'd0, 32'h1234_0000, 0);
    access("st_top", 1, 32'h3FC, 2'd2, 0, 32'hCAFE_F00D, 0, 4'b1111, 8'hFF, 32'hCAFE_F00D, 32'd0, 0);
    access("ld_top", 0, 32'h3FF, 2'd0, 1, 32'd0, 0, 4'b0000, 8'hFF, 32'd0, 32'h0000_00CA, 0);
    access("err_range", 0, 32'h400, 2'd2, 0, 32'd0, 1, 4'b0000, 8'd0, 32'd0, 32'd0, 1);
    access("err_range_st", 1, 32'h400, 2'd2, 0, 32'h5555_5555, 1, 4'b0000, 8'd0, 32'd0, 32'd0, 1);
    access("err_size3", 0, 32'h10, 2'd3, 0, 32'd0, 1, 4'b0000, 8'd0, 32'd0, 32'd0, 1);
`ifdef SRAM_LSU_BRIDGE_MISALIGN_ERR_EN
    access("mis_w", 0, 32'h12, 2'd2, 0, 32'd0, 1, 4'b0000, 8'd0, 32'd0, 32'd0, 1);
    access("mis_h", 1, 32'h11, 2'd1, 0, 32'h0000_BBBB, 1, 4'b0000, 8'd0, 32'd0, 32'd0, 1);
`else
    access("mis_w", 0, 32'h12, 2'd2, 0, 32'd0, 0, 4'b0000, 8'd4, 32'd0, 32'h8001_7FFF, 0);
    access("mis_h", 0, 32'h13, 2'd1, 0, 32'd0, 0, 4'b0000, 8'd4, 32'd0, 32'hFFFF_8001, 0);
`endif
    // the failed out-of-range store must not have written anything
    access("ld_after_err", 0, 32'h10, 2'd2, 0, 32'd0, 0, 4'b0000, 8'd4, 32'd0, 32'h8001_7FFF, 0);

    // response backpressure with a queued request
    rsp_ready = 1'b0;
    drive(1'b0, 32'h10, 2'd2, 1'b0, 32'd0);
    wait_ready("bp");
    @(posedge clk); #1;
    drive(1'b0, 32'h11, 2'd0, 1'b1, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("bp rsp_rdata", rsp_rdata, 32'h8001_7FFF);
      check_eq("bp req_ready", {31'd0, req_ready}, 32'd0);
      check_eq("bp csb0", {31'd0, csb0}, 32'd1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp2 req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("bp2 csb0", {31'd0, csb0}, 32'd0);
    check_eq("bp2 addr0", {24'd0, addr0}, 32'd4);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("bp2 rsp_valid early", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check_eq("bp2 rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("bp2 rsp_rdata", rsp_rdata, 32'h0000_007F);
    @(posedge clk); #1;
    check_eq("bp2 rsp_valid done", {31'd0, rsp_valid}, 32'd0);

    // reset in the middle of an access drops the response
    drive(1'b0, 32'h10, 2'd2, 1'b0, 32'd0);
    wait_ready("mid_rst");
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_eq("mid_rst req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst after rsp_valid", {31'd0, rsp_valid}, 32'd0);
    access("post_rst", 0, 32'h12, 2'd1, 1, 32'd0, 0, 4'b0000, 8'd4, 32'd0, 32'h0000_8001, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
